sn_stream_gen: RTL and testbench

SN_STREAM_GEN -- requirements
Module: sn_stream_gen

---
 rtl/sn_stream_gen.sv | 112 +++++++++++
 tb/tb_sn_stream_gen.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sn_stream_gen.sv
// Stochastic-number stream generator: emits a 2**NUM_BIT-cycle bit stream per channel whose
// ones count equals the latched operand. Define SN_BIPOLAR_EN for two's-complement operands.
module sn_stream_gen #(
  parameter int unsigned NUM_BIT = 8,
  parameter int unsigned DIM     = 16
) (
  input  logic                   i_clk_fsm_mux,
  input  logic                   i_rst_fsm_mux,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_hold,
  input  logic [DIM*NUM_BIT-1:0] i_x_bn,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic                   o_last,
  output logic                   o_done,
  output logic [NUM_BIT-1:0]     o_idx,
  output logic [DIM-1:0]         o_sn_bit
);

  localparam int unsigned        SelW   = (NUM_BIT > 1) ? $clog2(NUM_BIT) : 1;
  localparam logic [NUM_BIT-1:0] KMax   = '1;
  localparam logic [NUM_BIT-1:0] KOne   = NUM_BIT'(1);
  localparam logic [SelW-1:0]    SelOne = SelW'(1);
`ifdef SN_BIPOLAR_EN
  localparam bit Bipolar = 1'b1;
`else
  localparam bit Bipolar = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StGen} state_e;

  state_e                 state_q, state_d;
  logic [NUM_BIT-1:0]     k_q, k_d;
  logic [DIM*NUM_BIT-1:0] x_q, x_d;
  logic                   done_q, done_d;
  logic [SelW-1:0]        sel;
  logic                   ones_run;
  logic [NUM_BIT-1:0]     x_ch;

  always_ff @(posedge i_clk_fsm_mux or posedge i_rst_fsm_mux) begin
    if (i_rst_fsm_mux) begin
      state_q <= StIdle;
      k_q     <= '0;
      x_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      done_q  <= done_d;
    end
  end

  // k is cleared on every exit from GEN so o_idx reads 0 throughout IDLE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start && !i_stop) begin
          state_d = StGen;
          k_d     = '0;
          x_d     = i_x_bn;
        end
      end
      StGen: begin
        if (i_stop) begin
          state_d = StIdle;
          k_d     = '0;
        end else if (!i_hold) begin
          if (k_q == KMax) begin
            state_d = StIdle;
            k_d     = '0;
            done_d  = 1'b1;
          end else begin
            k_d = k_q + KOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // sel = NUM_BIT-1 minus the number of trailing ones of k.
  always_comb begin
    sel      = SelW'(NUM_BIT - 1);
    ones_run = 1'b1;
    for (int i = 0; i < int'(NUM_BIT) - 1; i++) begin
      ones_run = ones_run & k_q[i];
      if (ones_run) sel = sel - SelOne;
    end
  end

  always_comb begin
    o_busy   = (state_q == StGen);
    o_valid  = o_busy & ~i_hold;
    o_last   = o_valid & (k_q == KMax);
    o_done   = done_q;
    o_idx    = k_q;
    o_sn_bit = '0;
    x_ch     = '0;
    for (int c = 0; c < int'(DIM); c++) begin
      x_ch = x_q[c*NUM_BIT +: NUM_BIT];
      if (Bipolar) x_ch[NUM_BIT-1] = ~x_ch[NUM_BIT-1];
      if (o_valid && (k_q != KMax)) o_sn_bit[c] = x_ch[sel];
    end
  end

endmodule

// File: tb/tb_sn_stream_gen.sv
// Self-checking bench for sn_stream_gen (NUM_BIT=8, DIM=4) against a behavioural stream model.
module tb_sn_stream_gen;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        hold  = 1'b0;
  logic [31:0] x_bn  = '0;
  logic        busy, valid, last, done;
  logic [7:0]  idx;
  logic [3:0]  sn;

  int checks   = 0;
  int failures = 0;

  int obs_cycles, obs_valid, obs_last_k, obs_ch3_k, obs_ch1_bad;
  int obs_ones[4];
  bit obs_done, obs_timeout;

  sn_stream_gen #(.NUM_BIT(8), .DIM(4)) dut (
    .i_clk_fsm_mux(clk),
    .i_rst_fsm_mux(rst),
    .i_start      (start),
    .i_stop       (stop),
    .i_hold       (hold),
    .i_x_bn       (x_bn),
    .o_busy       (busy),
    .o_valid      (valid),
    .o_last       (last),
    .o_done       (done),
    .o_idx        (idx),
    .o_sn_bit     (sn)
  );

  always #5 clk = ~clk;

  // Stream bit for operand x at index k: MSB on even k, next bit when k ends in one 1, etc.
  function automatic logic exp_bit(input logic [7:0] x, input int k);
    int kk;
    int t;
    logic [7:0] v;
    if (k == 255) return 1'b0;
    v = x;
`ifdef SN_BIPOLAR_EN
    v = x ^ 8'h80;
`endif
    kk = k;
    t  = 0;
    while (kk % 2 == 1) begin
      kk = kk / 2;
      t++;
    end
    return v[7-t];
  endfunction

  function automatic int exp_ones(input logic [7:0] x);
`ifdef SN_BIPOLAR_EN
    return int'(x ^ 8'h80);
`else
    return int'(x);
`endif
  endfunction

  // Drives one stream from IDLE (called at posedge+1) and compares every cycle to the model.
  task automatic run_stream(input logic [31:0] ops, input int hold_at, input int hold_len,
                            input int hold_pct, input int stop_at, input int rst_at,
                            input bit scramble);
    int k;
    int held;
    bit fin;
    bit completed;
    logic [3:0]  e_sn;
    logic [15:0] got;
    logic [15:0] exp;
    obs_cycles = 0; obs_valid = 0; obs_last_k = -1; obs_ch3_k = -1; obs_ch1_bad = 0;
    obs_done = 0; obs_timeout = 0;
    for (int c = 0; c < 4; c++) obs_ones[c] = 0;
    x_bn = ops; start = 1'b1; stop = 1'b0; hold = 1'b0;
    @(posedge clk); #1;
    k = 0; held = 0; fin = 0; completed = 0;
    while (!fin) begin
      if (obs_cycles >= 600) begin
        checks++; failures++; obs_timeout = 1; fin = 1;
        $display("FAIL stream_timeout cycles=%0d k=%0d required completion", obs_cycles, k);
      end else if (k == rst_at) begin
        #2 rst = 1'b1;
        #1;
        got = {busy, valid, last, done, idx, sn};
        checks++;
        if (got !== 16'h0) begin
          failures++;
          $display("FAIL reset_mid_outputs got=%h required=0000", got);
        end
        fin = 1;
      end else begin
        start = 1'($urandom_range(1));
        stop  = (k == stop_at);
        if (stop) start = 1'b1;
        hold = (int'($urandom_range(99)) < hold_pct);
        if (k == hold_at && held < hold_len) begin
          hold = 1'b1;
          held++;
        end
        if (scramble) x_bn = $urandom;
        @(negedge clk);
        for (int c = 0; c < 4; c++) e_sn[c] = hold ? 1'b0 : exp_bit(ops[c*8 +: 8], k);
        exp = {1'b1, !hold, (!hold && k == 255), 1'b0, k[7:0], e_sn};
        got = {busy, valid, last, done, idx, sn};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL gen_cycle k=%0d got{busy,valid,last,done,idx,sn}=%h required=%h",
                   k, got, exp);
        end
        if (valid) begin
          obs_valid++;
          for (int c = 0; c < 4; c++) obs_ones[c] += int'(sn[c]);
          if (last) obs_last_k = int'(idx);
          if (sn[3]) obs_ch3_k = int'(idx);
          if (sn[1] != (idx[0] == 1'b0)) obs_ch1_bad++;
        end
        obs_cycles++;
        @(posedge clk); #1;
        if (stop) fin = 1;
        else if (!hold) begin
          if (k == 255) begin
            fin = 1;
            completed = 1;
          end else begin
            k++;
          end
        end
      end
    end
    start = 1'b0; stop = 1'b0; hold = 1'b0;
    if (rst_at < 0 && !obs_timeout) begin
      @(negedge clk);
      exp = {3'b000, completed, 8'h00, 4'h0};
      got = {busy, valid, last, done, idx, sn};
      obs_done = done;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL end_idle got{busy,valid,last,done,idx,sn}=%h required=%h", got, exp);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        failures++;
        $display("FAIL done_pulse_len got{busy,done}=%b required=00", {busy, done});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_ones(input string name, input logic [31:0] ops);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs_ones[c] != exp_ones(ops[c*8 +: 8])) begin
        failures++;
        $display("FAIL %s_ones ch=%0d got=%0d required=%0d", name, c, obs_ones[c],
                 exp_ones(ops[c*8 +: 8]));
      end
    end
  endtask

  task automatic test_reset;
    start = 1'b1;
    #3;
    checks++;
    if ({busy, valid, last, done, idx, sn} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0000", {busy, valid, last, done, idx, sn});
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, valid, done, idx} !== 11'h0) begin
      failures++;
      $display("FAIL reset_release_idle got=%h required=000", {busy, valid, done, idx});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [31:0] ops;
    ops = {8'h01, 8'hFF, 8'h80, 8'h00};
    run_stream(ops, -1, 0, 0, -1, -1, 1'b0);
    check_ones("basic", ops);
    checks++;
    if (obs_valid != 256 || obs_cycles != 256) begin
      failures++;
      $display("FAIL basic_len got valid=%0d cycles=%0d required 256/256", obs_valid, obs_cycles);
    end
    checks++;
    if (obs_last_k != 255 || obs_done != 1'b1) begin
      failures++;
      $display("FAIL basic_last_done got last_k=%0d done=%0b required 255/1", obs_last_k,
               obs_done);
    end
`ifndef SN_BIPOLAR_EN
    checks++;
    if (obs_ch3_k != 127) begin
      failures++;
      $display("FAIL basic_ch3_one_k got=%0d required=127", obs_ch3_k);
    end
    checks++;
    if (obs_ch1_bad != 0) begin
      failures++;
      $display("FAIL basic_ch1_even got=%0d bad cycles required=0", obs_ch1_bad);
    end
`endif
  endtask

  task automatic test_hold;
    logic [31:0] ops;
    ops = {8'h01, 8'hFF, 8'h80, 8'h00};
    run_stream(ops, 20, 5, 0, -1, -1, 1'b0);
    check_ones("hold", ops);
    checks++;
    if (obs_cycles != 261 || obs_valid != 256 || obs_done != 1'b1) begin
      failures++;
      $display("FAIL hold_len got cycles=%0d valid=%0d done=%0b required 261/256/1",
               obs_cycles, obs_valid, obs_done);
    end
  endtask

  task automatic test_stop;
    logic [31:0] ops;
    run_stream({8'h55, 8'hAA, 8'h3C, 8'hC3}, -1, 0, 0, 10, -1, 1'b0);
    checks++;
    if (obs_done != 1'b0 || obs_cycles != 11) begin
      failures++;
      $display("FAIL stop_abort got done=%0b cycles=%0d required 0/11", obs_done, obs_cycles);
    end
    ops = $urandom;
    run_stream(ops, -1, 0, 0, -1, -1, 1'b0);
    check_ones("stop_restart", ops);
  endtask

  task automatic test_reset_mid;
    logic [31:0] ops;
    run_stream($urandom, -1, 0, 0, -1, 100, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        failures++;
        $display("FAIL reset_mid_no_restart got{busy,done}=%b required=00", {busy, done});
      end
      @(posedge clk); #1;
    end
    ops = $urandom;
    run_stream(ops, -1, 0, 0, -1, -1, 1'b1);
    check_ones("reset_mid_latch", ops);
  endtask

  task automatic test_random;
    logic [31:0] ops;
    for (int n = 0; n < 4; n++) begin
      ops = $urandom;
      run_stream(ops, -1, 0, 20, -1, -1, 1'b1);
      check_ones("random", ops);
      checks++;
      if (obs_valid != 256 || obs_done != 1'b1) begin
        failures++;
        $display("FAIL random_len got valid=%0d done=%0b required 256/1", obs_valid, obs_done);
      end
    end
  endtask

`ifdef SN_BIPOLAR_EN
  task automatic test_bipolar;
    int req[4];
    req = '{128, 0, 255, 128};
    run_stream({8'h00, 8'h7F, 8'h80, 8'h00}, -1, 0, 0, -1, -1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs_ones[c] != req[c]) begin
        failures++;
        $display("FAIL bipolar_ones ch=%0d got=%0d required=%0d", c, obs_ones[c], req[c]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_stop();
    test_reset_mid();
    test_random();
`ifdef SN_BIPOLAR_EN
    test_bipolar();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
